// File: rtl/serial_adder_acc.sv
// Bit-serial add / subtract / accumulate unit.
// A single full-adder slice and a carry flip-flop process one operand bit
// per clock, LSB first. An operation takes WIDTH cycles after the start edge.
// The result, carry and overflow registers update together on the final edge.
module serial_adder_acc #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] res_sh_reg, res_sh_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;
    logic             done_reg, done_next;

    // B operand selected at the start edge.
    // Subtraction loads ~b and presets the carry, which forms a + ~b + 1.
    // Accumulation feeds the current sum back in as B.
    logic [WIDTH-1:0] b_load;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bsel
            assign b_load[gi] = (op == 2'b01) ? ~b[gi] :
                                (op == 2'b10) ? sum_reg[gi] : b[gi];
        end
    endgenerate

    // One full-adder slice working on the current LSBs of the shift registers
    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
    logic [WIDTH-1:0] res_shifted;

    assign s_bit       = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    assign c_bit       = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & carry_reg) |
                         (b_sh_reg[0] & carry_reg);
    assign last_bit    = (cnt_reg == CW'(WIDTH - 1));
    assign res_shifted = {s_bit, res_sh_reg[WIDTH-1:1]};

    // Next-state and datapath control; a start request takes priority over clr
    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_sh_next = res_sh_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        sum_next    = sum_reg;
        cout_next   = cout_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next   = a;
                    b_sh_next   = b_load;
                    res_sh_next = '0;
                    carry_next  = (op == 2'b01);
                    cnt_next    = '0;
                    state_next  = RUN;
                end else if (clr) begin
                    sum_next  = '0;
                    cout_next = 1'b0;
                    ovf_next  = 1'b0;
                end
            end
            RUN: begin
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                res_sh_next = res_shifted;
                carry_next  = c_bit;
                cnt_next    = cnt_reg + CW'(1);
                if (last_bit) begin
                    // The MSB operand bits are still at position 0 on this edge
                    sum_next   = res_shifted;
                    cout_next  = c_bit;
                    ovf_next   = (a_sh_reg[0] == b_sh_reg[0]) && (s_bit != a_sh_reg[0]);
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with synchronous reset; a reset mid-run abandons the operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_sh_reg <= res_sh_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            sum_reg    <= sum_next;
            cout_reg   <= cout_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign busy = (state_reg == RUN);
    assign done = done_reg;

endmodule

// File: tb/tb_serial_adder_acc.sv
// Self-checking bench for serial_adder_acc (WIDTH=8).
// Each accepted start pushes an expected result onto a queue.
// A monitor pops it when done pulses and checks the result, latency and busy length.
module tb_serial_adder_acc;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    serial_adder_acc #(.WIDTH(WIDTH), .CW(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .clr   (clr),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        time        t0;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_sum;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Arithmetic reference: 9-bit add or subtract on the raw operands
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
        exp_t       e;
        logic [8:0] full;
        logic [7:0] opnd;
        opnd = (o == 2'b10) ? model_sum : y;
        if (o == 2'b01) begin
            full   = {1'b0, x} - {1'b0, opnd};
            e.sum  = full[7:0];
            e.cout = ~full[8];
            e.ovf  = (x[7] != opnd[7]) && (full[7] != x[7]);
        end else begin
            full   = {1'b0, x} + {1'b0, opnd};
            e.sum  = full[7:0];
            e.cout = full[8];
            e.ovf  = (x[7] == opnd[7]) && (full[7] != x[7]);
        end
        e.t0 = 0;
        return e;
    endfunction

    // Call at a negedge while the DUT is idle, or in the done cycle.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
        exp_t e;
        start = 1'b1;
        a     = x;
        b     = y;
        op    = o;
        e     = model(x, y, o);
        @(posedge clk);
        e.t0      = $time;
        model_sum = e.sum;
        sb_q.push_back(e);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        $display("issue op=%0d a=0x%02h b=0x%02h -> expect sum=0x%02h cout=%0b ovf=%0b",
                 o, x, y, e.sum, e.cout, e.ovf);
    endtask

    task automatic wait_done(output time t_done);
        logic got;
        got    = 1'b0;
        t_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                got    = 1'b1;
                t_done = $time;
                break;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    // Monitor: pops and checks one expected result per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("latency", 32'(($time - 5 - e.t0) / 10), WIDTH);
                check("busy_len", 32'(busy_cnt), WIDTH);
                $display("done sum=0x%02h cout=%0b ovf=%0b busy_cycles=%0d",
                         sum, cout, ovf, busy_cnt);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    initial begin
        time t1, t2, t3;
        logic [7:0] prev;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        clr       = 1'b0;
        a         = '0;
        b         = '0;
        model_sum = '0;
        repeat (3) @(negedge clk);
        check("rst_sum", 32'(sum), 0);
        check("rst_flags", {29'b0, cout, ovf, busy}, 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain add, carry out, signed overflow, reserved op
        issue(8'h0F, 8'h01, 2'b00); wait_done(t1);
        @(negedge clk);
        issue(8'hFF, 8'h01, 2'b00); wait_done(t1);
        @(negedge clk);
        issue(8'h7F, 8'h01, 2'b00); wait_done(t1);
        @(negedge clk);
        issue(8'h22, 8'h11, 2'b11); wait_done(t1);
        @(negedge clk);

        // Subtract: borrow case, then signed overflow
        issue(8'h05, 8'h07, 2'b01); wait_done(t1);
        @(negedge clk);
        issue(8'h80, 8'h01, 2'b01); wait_done(t1);
        @(negedge clk);

        // Clear, then three back-to-back accumulates
        clr = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        model_sum = '0;
        check("clr_sum", 32'(sum), 0);
        check("clr_flags", {30'b0, cout, ovf}, 0);
        issue(8'h10, 8'hAA, 2'b10); wait_done(t1);
        issue(8'h10, 8'hAA, 2'b10); wait_done(t2);
        issue(8'h10, 8'hAA, 2'b10); wait_done(t3);
        check("b2b_gap1", 32'((t2 - t1) / 10), WIDTH + 1);
        check("b2b_gap2", 32'((t3 - t2) / 10), WIDTH + 1);
        @(negedge clk);

        // Start and clr while busy are ignored; sum holds mid-run
        prev = model_sum;
        issue(8'h0F, 8'h01, 2'b00);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 8'h55;
        op    = 2'b00;
        @(negedge clk);
        start = 1'b0;
        clr   = 1'b1;
        check("hold_mid_run", 32'(sum), 32'(prev));
        check("busy_mid_run", 32'(busy), 1);
        @(negedge clk);
        clr = 1'b0;
        wait_done(t1);
        @(negedge clk);

        // Reset after three RUN edges abandons the operation
        issue(8'h0F, 8'h01, 2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        model_sum = '0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_sum", 32'(sum), 0);
        check("mid_rst_flags", {30'b0, cout, ovf}, 0);
        repeat (12) @(negedge clk);
        issue(8'h03, 8'h04, 2'b00); wait_done(t1);
        @(negedge clk);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
